// File: rtl/lut_neuron_loader.sv
// Lookup-table neuron: a byte stream loads a 2^IN_BITS x OUT_BITS truth table,
// then registered lookups return one entry per cycle with a latency of one cycle.
module lut_neuron_loader #(
  parameter int unsigned IN_BITS  = 6,
  parameter int unsigned OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [7:0]          cfg_data,
  input  logic                cfg_last,
  output logic                load_done,
  output logic                load_err,
  output logic                table_valid,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data
);

  localparam int unsigned Entries = 2 ** IN_BITS;
  localparam int unsigned NBytes  = Entries * OUT_BITS / 8;
  localparam int unsigned CntW    = (NBytes > 1) ? $clog2(NBytes) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(NBytes - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StActive, StError} state_e;

  state_e                r_state, w_state_next;
  logic [CntW-1:0]       r_cnt;
  logic [NBytes*8-1:0]   r_table;
  logic                  r_load_done;
  logic                  r_out_valid;
  logic [OUT_BITS-1:0]   r_out_data;
  logic                  w_accept;
  logic                  w_at_last;
  logic                  w_lookup;

  // cfg_start wins over a byte handshaken in the same cycle
  assign w_accept  = (r_state == StLoad) && cfg_valid && !cfg_start;
  assign w_at_last = (r_cnt == LastIdx);
  assign w_lookup  = in_valid && (r_state == StActive) && !cfg_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (cfg_start) begin
      w_state_next = StLoad;
    end else if (w_accept) begin
      if (cfg_last && w_at_last) begin
        w_state_next = StActive;
      end else if (cfg_last || w_at_last) begin
        w_state_next = StError;
      end
    end
  end

  // Byte k lands on bits [8k+7:8k], so entry e sits at bits [e*OUT_BITS +: OUT_BITS]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_table     <= '0;
      r_load_done <= 1'b0;
    end else begin
      r_load_done <= w_accept && cfg_last && w_at_last;
      if (cfg_start) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_table[r_cnt*8 +: 8] <= cfg_data;
        r_cnt                 <= r_cnt + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= w_lookup;
      if (w_lookup) begin
        r_out_data <= r_table[in_data*OUT_BITS +: OUT_BITS];
      end
    end
  end

  assign cfg_ready   = (r_state == StLoad);
  assign load_done   = r_load_done;
  assign load_err    = (r_state == StError);
  assign table_valid = (r_state == StActive);
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;

endmodule

// File: doc/lut_neuron_loader.md
LUT_NEURON_LOADER -- requirements
Module: lut_neuron_loader

Interface
REQ-001 SHALL have parameter IN_BITS, default 6, neuron fan-in bit width (lookup address width).
REQ-002 SHALL have parameter OUT_BITS, default 2, neuron output width; OUT_BITS SHALL divide 8.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port cfg_start  in  1  one-cycle pulse that begins a table load.
REQ-006 SHALL have port cfg_valid  in  1  configuration byte valid.
REQ-007 SHALL have port cfg_ready  out  1  block accepts a configuration byte.
REQ-008 SHALL have port cfg_data  in  8  packed table entries.
REQ-009 SHALL have port cfg_last  in  1  marks the final configuration byte.
REQ-010 SHALL have port load_done  out  1  one-cycle pulse on successful load.
REQ-011 SHALL have port load_err  out  1  sticky error flag.
REQ-012 SHALL have port table_valid  out  1  table holds a complete, error-free load.
REQ-013 SHALL have port in_valid  in  1  lookup request valid.
REQ-014 SHALL have port in_data  in  IN_BITS  lookup address (neuron input vector).
REQ-015 SHALL have port out_valid  out  1  lookup result valid.
REQ-016 SHALL have port out_data  out  OUT_BITS  lookup result (neuron output).

Function
REQ-017 SHALL store 2^IN_BITS entries of OUT_BITS each; NBYTES = 2^IN_BITS*OUT_BITS/8 (16 at defaults).
REQ-018 SHALL use FSM states IDLE, LOAD, ACTIVE, ERROR.
REQ-019 SHALL, on cfg_start in any state, enter LOAD, clear byte counter to 0, clear table_valid and load_err.
REQ-020 SHALL assert cfg_ready only in LOAD; a byte is accepted when cfg_valid and cfg_ready are both 1.
REQ-021 SHALL write accepted byte k into entries k*(8/OUT_BITS) .. k*(8/OUT_BITS)+(8/OUT_BITS)-1, lowest entry in cfg_data[OUT_BITS-1:0], ascending with bit position.
REQ-022 SHALL, when byte NBYTES-1 is accepted with cfg_last=1, enter ACTIVE, set table_valid, pulse load_done the following cycle.
REQ-023 SHALL, when cfg_last=1 on byte index < NBYTES-1, or cfg_last=0 on byte NBYTES-1, enter ERROR, set load_err, leave table_valid 0.
REQ-024 SHALL ignore cfg_valid/cfg_data/cfg_last outside LOAD; cfg_start SHALL take priority over a byte accepted in the same cycle (byte discarded).
REQ-025 SHALL hold ERROR until cfg_start or reset; IDLE is left only by cfg_start.
REQ-026 SHALL, in ACTIVE, register table[in_data] to out_data and in_valid to out_valid: latency exactly 1 cycle, throughput 1 lookup/cycle.
REQ-027 SHALL drive out_valid 0 when state is not ACTIVE in the request cycle; out_data SHALL hold its previous value when out_valid is 0.
REQ-028 SHALL, if cfg_start arrives in ACTIVE, still deliver out_valid for a lookup issued the previous cycle, then suppress lookups.
REQ-029 SHALL interpret in_data bit 0 as the least-significant address bit.

Reset
REQ-030 SHALL, while rst_n=0, force state IDLE, counter 0, cfg_ready 0, load_done 0, load_err 0, table_valid 0, out_valid 0, out_data 0.
REQ-031 SHALL clear all table entries to 0 on reset; reset mid-load SHALL discard the partial load.
REQ-032 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Verification
REQ-033 SHALL cover: reset, cfg_start, 16 bytes 0xE4 with cfg_last on byte 15 -> load_done one pulse, table_valid=1; lookup in_data=0,1,2,3 -> out_data=0,1,2,3 one cycle later.
REQ-034 SHALL cover: cfg_last on byte 9 -> load_err=1, table_valid=0, cfg_ready=0; lookup in_data=5 -> out_valid stays 0.
REQ-035 SHALL cover: 16 bytes without cfg_last -> ERROR; then cfg_start plus a correct load -> load_err cleared, table_valid=1.
REQ-036 SHALL cover: back-to-back lookups 0..63 every cycle after a load of byte k = k -> 64 consecutive out_valid, entry 4k+1 = k[3:2], entry 4k = k[1:0], etc.
REQ-037 SHALL cover: rst_n low after byte 7 of a load -> all outputs 0; post-reset lookups give out_valid=0 until a new complete load.
REQ-038 SHALL cover: cfg_valid toggled randomly during LOAD -> only handshaken bytes counted; the table matches the accepted byte sequence.
